frame_scan_ctrl: RTL and testbench
==================================

# frame_scan_ctrl

Sequencer that drives the pixel-address stream for one full-screen framebuffer pass in the Pong display path. On a start pulse it walks x across each line and y down the frame, presenting one (x, y) pixel address per transfer on a valid/ready handshake toward the LCD write interface. It inserts an optional idle gap after each line and reports frame completion. It sits between the game-render logic, which issues start and abort, and the LCD pixel writer, which consumes x/y/valid.

## Interface
- X_LAST, 239, last x index; line length is X_LAST+1; range 1..255
- Y_LAST, 319, last y index; frame height is Y_LAST+1; range 1..511
- LINE_GAP, 0, idle cycles inserted after every line except the last; range 0..255

- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- start  in  1  single-cycle request to begin a frame; ignored while busy
- abort  in  1  synchronous; terminates the current frame immediately
- pixel_ready  in  1  downstream accepts the current pixel this cycle
- pixel_valid  out  1  x/y hold a pixel address awaiting acceptance
- x  out  8  current pixel column
- y  out  9  current pixel row
- sof  out  1  first pixel of the frame being presented
- eol  out  1  last pixel of a line being presented
- busy  out  1  a frame is in progress (FRAME or GAP)
- done  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- States: IDLE, FRAME, GAP. All outputs are registered except sof and eol.
- Reset values: state=IDLE, x=0, y=0, pixel_valid=0, busy=0, done=0. sof=0 and eol=0 follow from these.
- Combinational flags:
  - sof = pixel_valid & (x==0) & (y==0)
  - eol = pixel_valid & (x==X_LAST)
- A transfer occurs in any cycle with pixel_valid & pixel_ready.
- IDLE:
  - start=1 -> FRAME; x=0, y=0, pixel_valid=1, busy=1.
  - Otherwise hold.
- FRAME, transfer with x<X_LAST: x<=x+1, y unchanged.
- FRAME, transfer with x==X_LAST and y<Y_LAST:
  - x<=0, y<=y+1.
  - If LINE_GAP==0, stay in FRAME with pixel_valid=1.
  - Otherwise enter GAP with pixel_valid=0 and gap counter=LINE_GAP-1.
- FRAME, transfer with x==X_LAST and y==Y_LAST: go to IDLE; x=0, y=0, pixel_valid=0, busy=0, done=1 for one cycle.
- FRAME, no transfer: x, y and pixel_valid hold. pixel_valid never drops without a transfer, except on abort or reset.
- GAP:
  - Counter decrements each cycle.
  - Counter==0 -> FRAME with pixel_valid=1.
  - pixel_ready is ignored.
- abort=1 in any state, next cycle: IDLE, x=0, y=0, pixel_valid=0, busy=0. done is not pulsed.
- Priority: reset > abort > transfer/gap progression > start.
- start while busy has no effect. start in the same cycle as done (block already in IDLE) begins a new frame.
- Counters never exceed X_LAST/Y_LAST. There is no wrap beyond the frame.

## Timing
- start sampled at edge N -> pixel_valid=1, x=0, y=0 after edge N+1.
- Throughput with pixel_ready held high: one pixel per clock within a line.
- Total cycles from first valid to done with ready held high: (X_LAST+1)(Y_LAST+1) + Y_LAST*LINE_GAP. done rises one edge after the final transfer.
- Reset mid-frame: outputs take their reset values asynchronously. The next frame requires a new start.
- done is high for exactly one cycle, and busy=0 in that same cycle.

## Test plan
- Basic frame (X_LAST=3, Y_LAST=2, LINE_GAP=0), pixel_ready=1, start at cycle 0:
  - Required: 12 transfers in order (0,0)..(3,2).
  - sof only at (0,0); eol at x=3 on each of the three rows.
  - done pulse at cycle 13; busy low from cycle 13.
- Line gap (X_LAST=3, Y_LAST=2, LINE_GAP=2), ready=1:
  - Required: pixel_valid low for exactly 2 cycles after (3,0) and after (3,1), none after (3,2).
  - done 16 cycles after the first valid.
- Backpressure: hold pixel_ready=0 for 5 cycles at (2,1).
  - Required: x=2, y=1, valid=1 stable throughout; the sequence resumes at (3,1) after ready returns.
- Abort at (1,1) with ready=1:
  - Required: next cycle valid=0, x=0, y=0, busy=0; done never asserts.
  - A following start restarts at (0,0).
- start pulses at (2,0) mid-frame are ignored, with the sequence unchanged. start in the done cycle launches a second frame with valid the next cycle.
- Async reset asserted mid-GAP, between clock edges:
  - Required: all outputs return to reset values immediately.
  - The block stays in IDLE after release until start.

Source files
------------

// File: rtl/frame_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scan_ctrl
//  Description : Pixel-address sequencer for one full-screen framebuffer pass.
//                On start it presents (x, y) addresses on a valid/ready
//                handshake. It walks x across each line and y down the frame,
//                optionally idles LINE_GAP cycles between lines, and pulses
//                done after the final pixel is accepted.
//  Ports       : clock, reset (async, active-high)
//                start, abort       - control from the render logic
//                pixel_ready        - downstream accept
//                pixel_valid, x, y  - registered pixel address stream
//                sof, eol           - combinational frame/line markers
//                busy, done         - registered status
//  Revision    : 1.0  initial release
// ============================================================================
module frame_scan_ctrl #(
    parameter int X_LAST   = 239,
    parameter int Y_LAST   = 319,
    parameter int LINE_GAP = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       pixel_ready,
    output logic       pixel_valid,
    output logic [7:0] x,
    output logic [8:0] y,
    output logic       sof,
    output logic       eol,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] c_x_last   = 8'(X_LAST);
    localparam logic [8:0] c_y_last   = 9'(Y_LAST);
    // Only meaningful when LINE_GAP > 0; the counter counts down to zero.
    localparam logic [7:0] c_gap_load = 8'(LINE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     r_state, w_state_nx;
    logic [7:0] r_x, w_x_nx;
    logic [8:0] r_y, w_y_nx;
    logic [7:0] r_gap, w_gap_nx;
    logic       r_valid, w_valid_nx;
    logic       r_busy, w_busy_nx;
    logic       r_done, w_done_nx;
    logic       w_xfer;

    assign w_xfer = r_valid & pixel_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_gap   <= w_gap_nx;
            r_valid <= w_valid_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_gap_nx   = r_gap;
        w_valid_nx = r_valid;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;

        if (abort) begin
            // Abort wins over any progression and never produces done.
            w_state_nx = IDLE;
            w_x_nx     = '0;
            w_y_nx     = '0;
            w_gap_nx   = '0;
            w_valid_nx = 1'b0;
            w_busy_nx  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nx = FRAME;
                        w_x_nx     = '0;
                        w_y_nx     = '0;
                        w_valid_nx = 1'b1;
                        w_busy_nx  = 1'b1;
                    end
                end
                FRAME: begin
                    if (w_xfer) begin
                        if (r_x < c_x_last) begin
                            w_x_nx = r_x + 8'd1;
                        end else if (r_y < c_y_last) begin
                            w_x_nx = '0;
                            w_y_nx = r_y + 9'd1;
                            if (LINE_GAP != 0) begin
                                w_state_nx = GAP;
                                w_valid_nx = 1'b0;
                                w_gap_nx   = c_gap_load;
                            end
                        end else begin
                            w_state_nx = IDLE;
                            w_x_nx     = '0;
                            w_y_nx     = '0;
                            w_valid_nx = 1'b0;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
                GAP: begin
                    // pixel_ready is deliberately ignored while idling.
                    if (r_gap == 8'd0) begin
                        w_state_nx = FRAME;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_gap_nx = r_gap - 8'd1;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_x_nx     = '0;
                    w_y_nx     = '0;
                    w_valid_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                end
            endcase
        end
    end

    assign pixel_valid = r_valid;
    assign x           = r_x;
    assign y           = r_y;
    assign busy        = r_busy;
    assign done        = r_done;
    assign sof         = r_valid & (r_x == 8'd0) & (r_y == 9'd0);
    assign eol         = r_valid & (r_x == c_x_last);

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scan_ctrl
//  Description : Directed self-checking bench for frame_scan_ctrl. Two
//                instances (4x3 frame, no line gap and 2-cycle line gap)
//                share clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_scan_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    logic       start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
    logic       v0, sof0, eol0, busy0, done0;
    logic [7:0] x0;
    logic [8:0] y0;

    logic       start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
    logic       v1, sof1, eol1, busy1, done1;
    logic [7:0] x1;
    logic [8:0] y1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    frame_scan_ctrl #(.X_LAST(3), .Y_LAST(2), .LINE_GAP(0)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .abort(abort0),
        .pixel_ready(ready0), .pixel_valid(v0), .x(x0), .y(y0),
        .sof(sof0), .eol(eol0), .busy(busy0), .done(done0)
    );

    frame_scan_ctrl #(.X_LAST(3), .Y_LAST(2), .LINE_GAP(2)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .abort(abort1),
        .pixel_ready(ready1), .pixel_valid(v1), .x(x1), .y(y1),
        .sof(sof1), .eol(eol1), .busy(busy1), .done(done1)
    );

    task automatic test_reset();
        #2;
        checks++;
        if ({v0, x0, y0, sof0, eol0, busy0, done0} !== 22'd0) begin
            errors++;
            $display("FAIL reset_hold: got v=%b x=%0d y=%0d sof=%b eol=%b busy=%b done=%b, required all 0",
                     v0, x0, y0, sof0, eol0, busy0, done0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({v0, x0, y0, busy0, done0, v1, busy1, done1} !== 23'd0) begin
            errors++;
            $display("FAIL reset_idle: got v0=%b x0=%0d y0=%0d busy0=%b done0=%b v1=%b busy1=%b done1=%b, required all 0",
                     v0, x0, y0, busy0, done0, v1, busy1, done1);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] ex;
        logic [8:0] ey;
        ready0 = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ex = 8'(i % 4);
            ey = 9'(i / 4);
            checks++;
            if (v0 !== 1'b1 || x0 !== ex || y0 !== ey || sof0 !== (i == 0) ||
                eol0 !== (ex == 8'd3) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                errors++;
                $display("FAIL basic_pixel%0d: got v=%b x=%0d y=%0d sof=%b eol=%b busy=%b done=%b, required v=1 x=%0d y=%0d sof=%b eol=%b busy=1 done=0",
                         i, v0, x0, y0, sof0, eol0, busy0, done0, ex, ey, (i == 0), (ex == 8'd3));
            end
            @(negedge clock);
        end
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || v0 !== 1'b0 || x0 !== 8'd0 || y0 !== 9'd0) begin
            errors++;
            $display("FAIL basic_done: got done=%b busy=%b v=%b x=%0d y=%0d, required done=1 busy=0 v=0 x=0 y=0",
                     done0, busy0, v0, x0, y0);
        end
        @(negedge clock);
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b, required done=0 busy=0", done0, busy0);
        end
    endtask

    task automatic test_line_gap();
        logic       ev;
        int         p;
        logic [7:0] ex;
        logic [8:0] ey;
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            ev = !(c == 4 || c == 5 || c == 10 || c == 11);
            p  = c - ((c >= 6) ? 2 : 0) - ((c >= 12) ? 2 : 0);
            ex = 8'(p % 4);
            ey = 9'(p / 4);
            checks++;
            if (v1 !== ev || done1 !== 1'b0 || busy1 !== 1'b1 || (ev && (x1 !== ex || y1 !== ey))) begin
                errors++;
                $display("FAIL gap_cycle%0d: got v=%b x=%0d y=%0d busy=%b done=%b, required v=%b x=%0d y=%0d busy=1 done=0",
                         c, v1, x1, y1, busy1, done1, ev, ex, ey);
            end
            @(negedge clock);
        end
        checks++;
        if (done1 !== 1'b1 || v1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL gap_done: got done=%b v=%b busy=%b, required done=1 v=0 busy=0", done1, v1, busy1);
        end
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        ready0 = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        repeat (6) @(negedge clock);
        ready0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (v0 !== 1'b1 || x0 !== 8'd2 || y0 !== 9'd1) begin
                errors++;
                $display("FAIL stall%0d: got v=%b x=%0d y=%0d, required v=1 x=2 y=1", i, v0, x0, y0);
            end
        end
        ready0 = 1'b1;
        @(negedge clock);
        checks++;
        if (v0 !== 1'b1 || x0 !== 8'd3 || y0 !== 9'd1 || eol0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: got v=%b x=%0d y=%0d eol=%b, required v=1 x=3 y=1 eol=1", v0, x0, y0, eol0);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (done0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got done=%b, required 1", done0);
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        logic saw_done;
        ready0 = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (x0 !== 8'd1 || y0 !== 9'd1) begin
            errors++;
            $display("FAIL abort_pos: got x=%0d y=%0d, required x=1 y=1", x0, y0);
        end
        abort0 = 1'b1;
        @(negedge clock);
        abort0 = 1'b0;
        checks++;
        if (v0 !== 1'b0 || x0 !== 8'd0 || y0 !== 9'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got v=%b x=%0d y=%0d busy=%b done=%b, required all 0",
                     v0, x0, y0, busy0, done0);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done0 !== 1'b0 || v0 !== 1'b0) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got activity=%b after abort, required 0", saw_done);
        end
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        checks++;
        if (v0 !== 1'b1 || x0 !== 8'd0 || y0 !== 9'd0 || sof0 !== 1'b1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got v=%b x=%0d y=%0d sof=%b busy=%b, required v=1 x=0 y=0 sof=1 busy=1",
                     v0, x0, y0, sof0, busy0);
        end
        abort0 = 1'b1;
        @(negedge clock);
        abort0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready0 = 1'b1;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        repeat (2) @(negedge clock);
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        checks++;
        if (v0 !== 1'b1 || x0 !== 8'd3 || y0 !== 9'd0) begin
            errors++;
            $display("FAIL start_ignored: got v=%b x=%0d y=%0d, required v=1 x=3 y=0", v0, x0, y0);
        end
        repeat (9) @(negedge clock);
        checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: got done=%b busy=%b, required done=1 busy=0", done0, busy0);
        end
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        checks++;
        if (v0 !== 1'b1 || x0 !== 8'd0 || y0 !== 9'd0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got v=%b x=%0d y=%0d busy=%b done=%b, required v=1 x=0 y=0 busy=1 done=0",
                     v0, x0, y0, busy0, done0);
        end
        abort0 = 1'b1;
        @(negedge clock);
        abort0 = 1'b0;
    endtask

    task automatic test_async_reset();
        ready1 = 1'b1;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (v1 !== 1'b0 || busy1 !== 1'b1 || y1 !== 9'd1) begin
            errors++;
            $display("FAIL in_gap: got v=%b busy=%b y=%0d, required v=0 busy=1 y=1", v1, busy1, y1);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({v1, x1, y1, sof1, eol1, busy1, done1} !== 22'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b x=%0d y=%0d sof=%b eol=%b busy=%b done=%b, required all 0",
                     v1, x1, y1, sof1, eol1, busy1, done1);
        end
        #1 reset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if (v1 !== 1'b0 || busy1 !== 1'b0 || x1 !== 8'd0 || y1 !== 9'd0) begin
            errors++;
            $display("FAIL reset_stay_idle: got v=%b busy=%b x=%0d y=%0d, required all 0", v1, busy1, x1, y1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_line_gap();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
